tree_feature_loader: RTL and testbench

Front end for the combinational decision-tree classifiers (51-bit feature vector in, 1-bit class out). It takes a byte-serial feature stream on a valid/ready handshake and assembles it into the 51-bit vector that drives the tree's input. It waits a programmable settle time, captures the tree's 1-bit result and returns it on a valid/ready result channel. One loader drives one tree instance.

---
 rtl/tree_pkg.sv | 49 ++++
 rtl/tree_settle_cnt.sv | 35 +++
 rtl/tree_feature_loader.sv | 167 ++++++++++++++++
 tb/tb_tree_feature_loader.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tree_pkg
//  Description : Shared widths, loader state encoding and the beat-insert
//                helper used by the decision-tree feature loader.
//  Revision    : 1.0  initial release
// ============================================================================
package tree_pkg;

  // Feature vector width; must equal the tree input width.
  localparam int FEAT_W   = 51;
  // Stream beat width.
  localparam int CHUNK_W  = 8;
  // Beats per frame, rounded up so the final partial beat is included.
  localparam int N_CHUNK  = (FEAT_W + CHUNK_W - 1) / CHUNK_W;
  // Beat counter width; must hold N_CHUNK so the post-frame value fits.
  localparam int CNT_W    = 3;
  // Settle counter width; covers SETTLE values 1..15.
  localparam int SETTLE_W = 4;

  // Loader state. Literals carry an ST_ prefix so they cannot collide with
  // the SETTLE parameter of the loader.
  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_DROP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_OUT    = 2'd3
  } tree_ld_state_t;

  // Writes one beat into its slice of the feature vector. Bits of the beat
  // that would land above FEAT_W-1 simply have no destination, which gives
  // the truncation of the final partial beat for free.
  function automatic logic [FEAT_W-1:0] put_beat(
    input logic [FEAT_W-1:0]  feat,
    input logic [CHUNK_W-1:0] data,
    input logic [CNT_W-1:0]   idx
  );
    logic [FEAT_W-1:0] w_res;
    w_res = feat;
    for (int b = 0; b < FEAT_W; b++) begin
      if ((b / CHUNK_W) == int'(idx)) begin
        w_res[b] = data[b % CHUNK_W];
      end
    end
    return w_res;
  endfunction

endpackage : tree_pkg
`default_nettype wire

// File: rtl/tree_settle_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : tree_settle_cnt
//  Description : Loadable down-counter with a zero flag; times how long the
//                tree output is allowed to settle before it is sampled.
//  Revision    : 1.0  initial release
// ============================================================================
module tree_settle_cnt
  import tree_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic [SETTLE_W-1:0] i_load_val,
  input  logic                i_dec,
  output logic                o_zero
);

  logic [SETTLE_W-1:0] r_cnt;

  // Load takes priority over decrement; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule : tree_settle_cnt
`default_nettype wire

// File: rtl/tree_feature_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tree_feature_loader
//  Description : Assembles a byte-serial feature stream into the 51-bit tree
//                input, waits SETTLE cycles, captures the 1-bit class and
//                returns it on a valid/ready result channel.
//  Revision    : 1.0  initial release
// ============================================================================
module tree_feature_loader
  import tree_pkg::*;
#(
  // Cycles between vector completion and result sampling, 1..15.
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [CHUNK_W-1:0] s_data,
  input  logic               s_last,
  output logic [FEAT_W-1:0]  feat_o,
  input  logic               class_i,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_class,
  output logic               err_len
);

  localparam logic [SETTLE_W-1:0] c_SETTLE_VAL = SETTLE_W'(SETTLE);
  localparam logic [CNT_W-1:0]    c_LAST_BEAT  = CNT_W'(N_CHUNK - 1);

  tree_ld_state_t    r_state;
  tree_ld_state_t    w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [FEAT_W-1:0] r_feat;
  logic [FEAT_W-1:0] w_feat_nxt;
  logic              r_m_valid;
  logic              w_m_valid_nxt;
  logic              r_m_class;
  logic              w_m_class_nxt;
  logic              r_err_len;
  logic              w_err_len_nxt;
  logic              w_settle_load;
  logic              w_settle_dec;
  logic              w_settle_zero;
  logic              w_s_ready;
  logic              w_xfer;

  // Beats are only taken while assembling or flushing a bad frame, so a new
  // frame can never overlap a pending result.
  assign w_s_ready = (r_state == ST_LOAD) || (r_state == ST_DROP);
  assign w_xfer    = s_valid && w_s_ready;

  tree_settle_cnt u_settle_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_settle_load),
    .i_load_val (c_SETTLE_VAL),
    .i_dec      (w_settle_dec),
    .o_zero     (w_settle_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers: beat count, feature vector, result and error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_feat    <= '0;
      r_m_valid <= 1'b0;
      r_m_class <= 1'b0;
      r_err_len <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_feat    <= w_feat_nxt;
      r_m_valid <= w_m_valid_nxt;
      r_m_class <= w_m_class_nxt;
      r_err_len <= w_err_len_nxt;
    end
  end

  // Next-state and datapath update; everything holds unless a case says so.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_feat_nxt    = r_feat;
    w_m_valid_nxt = r_m_valid;
    w_m_class_nxt = r_m_class;
    w_err_len_nxt = 1'b0;
    w_settle_load = 1'b0;
    w_settle_dec  = 1'b0;

    case (r_state)
      ST_LOAD: begin
        if (w_xfer) begin
          if (r_cnt == c_LAST_BEAT) begin
            w_feat_nxt = put_beat(r_feat, s_data, r_cnt);
            w_cnt_nxt  = r_cnt + 1'b1;
            if (s_last) begin
              w_state_nxt   = ST_SETTLE;
              w_settle_load = 1'b1;
            end else begin
              // Frame too long: flag it now and flush the remainder.
              w_err_len_nxt = 1'b1;
              w_state_nxt   = ST_DROP;
            end
          end else if (s_last) begin
            // Frame too short: throw the partial vector away and restart.
            w_err_len_nxt = 1'b1;
            w_cnt_nxt     = '0;
            w_feat_nxt    = '0;
          end else begin
            w_feat_nxt = put_beat(r_feat, s_data, r_cnt);
            w_cnt_nxt  = r_cnt + 1'b1;
          end
        end
      end

      ST_DROP: begin
        if (w_xfer && s_last) begin
          w_cnt_nxt   = '0;
          w_feat_nxt  = '0;
          w_state_nxt = ST_LOAD;
        end
      end

      ST_SETTLE: begin
        if (w_settle_zero) begin
          w_m_class_nxt = class_i;
          w_m_valid_nxt = 1'b1;
          w_state_nxt   = ST_OUT;
        end else begin
          w_settle_dec = 1'b1;
        end
      end

      ST_OUT: begin
        if (r_m_valid && m_ready) begin
          w_m_valid_nxt = 1'b0;
          w_cnt_nxt     = '0;
          w_feat_nxt    = '0;
          w_state_nxt   = ST_LOAD;
        end
      end

      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  assign s_ready = w_s_ready;
  assign feat_o  = r_feat;
  assign m_valid = r_m_valid;
  assign m_class = r_m_class;
  assign err_len = r_err_len;

endmodule : tree_feature_loader
`default_nettype wire

// File: tb/tb_tree_feature_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tree_feature_loader
//  Description : Self-checking bench for tree_feature_loader. Instance 0 runs
//                with SETTLE=1 and a tree stub returning feat_o[0]; instance 1
//                runs with SETTLE=5 and a parity tree stub.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tree_feature_loader;
  import tree_pkg::*;

  localparam int c_S0 = 1;
  localparam int c_S1 = 5;

  typedef struct {
    logic [FEAT_W-1:0] feat;
    logic              cls;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n   [2];
  logic               s_valid [2];
  logic               s_ready [2];
  logic [CHUNK_W-1:0] s_data  [2];
  logic               s_last  [2];
  logic [FEAT_W-1:0]  feat_o  [2];
  logic               class_i [2];
  logic               m_valid [2];
  logic               m_ready [2];
  logic               m_class [2];
  logic               err_len [2];

  exp_t               q0[$];
  exp_t               q1[$];
  logic [CHUNK_W-1:0] beats[16];
  int                 total = 0;
  int                 bad   = 0;
  int                 err_cnt[2];
  int                 hs_cnt[2];
  int                 mv_hi[2];

  always #5 clk = ~clk;

  assign class_i[0] = feat_o[0][0];
  assign class_i[1] = ^feat_o[1];

  tree_feature_loader #(.SETTLE(c_S0)) u_dut0 (
    .clk     (clk),
    .rst_n   (rst_n[0]),
    .s_valid (s_valid[0]),
    .s_ready (s_ready[0]),
    .s_data  (s_data[0]),
    .s_last  (s_last[0]),
    .feat_o  (feat_o[0]),
    .class_i (class_i[0]),
    .m_valid (m_valid[0]),
    .m_ready (m_ready[0]),
    .m_class (m_class[0]),
    .err_len (err_len[0])
  );

  tree_feature_loader #(.SETTLE(c_S1)) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n[1]),
    .s_valid (s_valid[1]),
    .s_ready (s_ready[1]),
    .s_data  (s_data[1]),
    .s_last  (s_last[1]),
    .feat_o  (feat_o[1]),
    .class_i (class_i[1]),
    .m_valid (m_valid[1]),
    .m_ready (m_ready[1]),
    .m_class (m_class[1]),
    .err_len (err_len[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference vector built from the beat table, independent of the RTL helper.
  function automatic logic [FEAT_W-1:0] model_feat(input int n);
    logic [N_CHUNK*CHUNK_W-1:0] w;
    w = '0;
    for (int k = 0; k < n && k < N_CHUNK; k++) w[k*CHUNK_W +: CHUNK_W] = beats[k];
    return w[FEAT_W-1:0];
  endfunction

  task automatic push_exp(input int i);
    exp_t e;
    e.feat = model_feat(N_CHUNK);
    e.cls  = (i == 0) ? e.feat[0] : ^e.feat;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that took the beat.
  task automatic send_beat(input int i, input logic [CHUNK_W-1:0] d, input logic l);
    int n;
    n = 0;
    s_valid[i] = 1'b1;
    s_data[i]  = d;
    s_last[i]  = l;
    @(negedge clk);
    while (s_ready[i] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("beat_accept_timeout", 64'(s_ready[i]), 64'd1);
    @(posedge clk);
    #1;
    s_valid[i] = 1'b0;
    s_last[i]  = 1'b0;
  endtask

  task automatic send_frame(input int i, input int n, input bit push);
    if (push) push_exp(i);
    for (int k = 0; k < n; k++) send_beat(i, beats[k], (k == n - 1));
  endtask

  task automatic rand_beats();
    for (int k = 0; k < 16; k++) beats[k] = 8'($urandom_range(0, 255));
  endtask

  // Returns the number of rising edges until m_valid is seen high.
  task automatic wait_mvalid(input int i, output int n);
    n = 0;
    while (m_valid[i] !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 40) chk("mvalid_timeout", 64'(m_valid[i]), 64'd1);
  endtask

  task automatic wait_result(input int i);
    int h;
    int n;
    h = hs_cnt[i];
    n = 0;
    while (hs_cnt[i] == h && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("result_handshake", 64'(hs_cnt[i] - h), 64'd1);
  endtask

  // Scoreboard and pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (rst_n[i] === 1'b1) begin
        if (err_len[i] === 1'b1) err_cnt[i]++;
        if (m_valid[i] === 1'b1) mv_hi[i]++;
        if (m_valid[i] === 1'b1 && m_ready[i] === 1'b1) begin
          hs_cnt[i]++;
          chk("sb_pending", 64'((i == 0) ? q0.size() : q1.size()), 64'd1);
          if ((i == 0 ? q0.size() : q1.size()) != 0) begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk("res_class", 64'(m_class[i]), 64'(e.cls));
            chk("res_feat", 64'(feat_o[i]), 64'(e.feat));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int e0;
    int h0;
    int m0;
    logic [FEAT_W-1:0] hold_feat;
    logic              hold_cls;

    for (int i = 0; i < 2; i++) begin
      rst_n[i]   = 1'b0;
      s_valid[i] = 1'b0;
      s_data[i]  = '0;
      s_last[i]  = 1'b0;
      m_ready[i] = 1'b1;
      err_cnt[i] = 0;
      hs_cnt[i]  = 0;
      mv_hi[i]   = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_s_ready", 64'(s_ready[i]), 64'd1);
      chk("rst_m_valid", 64'(m_valid[i]), 64'd0);
      chk("rst_m_class", 64'(m_class[i]), 64'd0);
      chk("rst_feat",    64'(feat_o[i]),  64'd0);
      chk("rst_err_len", 64'(err_len[i]), 64'd0);
    end
    @(posedge clk);
    #1;

    // Nominal frame on the SETTLE=1 instance.
    for (int k = 0; k < 7; k++) beats[k] = 8'(k + 1);
    send_frame(0, 7, 1'b1);
    wait_mvalid(0, n);
    chk("nom_latency", 64'(n), 64'(c_S0 + 1));
    chk("nom_feat", 64'(feat_o[0]), 64'h7060504030201);
    chk("nom_class", 64'(m_class[0]), 64'd1);
    chk("nom_s_ready_out", 64'(s_ready[0]), 64'd0);
    @(posedge clk);
    #1;
    chk("nom_s_ready_back", 64'(s_ready[0]), 64'd1);
    chk("nom_m_valid_drop", 64'(m_valid[0]), 64'd0);

    // Backpressure: result must hold while the consumer stalls.
    m_ready[0] = 1'b0;
    rand_beats();
    send_frame(0, 7, 1'b1);
    hold_feat = model_feat(N_CHUNK);
    hold_cls  = hold_feat[0];
    wait_mvalid(0, n);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("bp_m_valid", 64'(m_valid[0]), 64'd1);
      chk("bp_m_class", 64'(m_class[0]), 64'(hold_cls));
      chk("bp_feat",    64'(feat_o[0]),  64'(hold_feat));
      chk("bp_s_ready", 64'(s_ready[0]), 64'd0);
    end
    h0 = hs_cnt[0];
    m_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    m_ready[0] = 1'b0;
    chk("bp_handshake", 64'(hs_cnt[0] - h0), 64'd1);
    chk("bp_m_valid_done", 64'(m_valid[0]), 64'd0);
    chk("bp_s_ready_back", 64'(s_ready[0]), 64'd1);
    m_ready[0] = 1'b1;

    // Short frame: s_last on beat 3.
    e0 = err_cnt[0];
    m0 = mv_hi[0];
    rand_beats();
    send_frame(0, 4, 1'b0);
    @(posedge clk);
    #1;
    chk("short_err_cnt", 64'(err_cnt[0] - e0), 64'd1);
    chk("short_feat_clr", 64'(feat_o[0]), 64'd0);
    chk("short_s_ready", 64'(s_ready[0]), 64'd1);
    chk("short_no_result", 64'(mv_hi[0] - m0), 64'd0);
    rand_beats();
    send_frame(0, 7, 1'b1);
    wait_result(0);

    // Long frame: nine beats, s_last on beat 8.
    e0 = err_cnt[0];
    m0 = mv_hi[0];
    rand_beats();
    for (int k = 0; k < 7; k++) send_beat(0, beats[k], 1'b0);
    chk("long_err_on_beat6", 64'(err_len[0]), 64'd1);
    send_beat(0, beats[7], 1'b0);
    send_beat(0, beats[8], 1'b1);
    @(posedge clk);
    #1;
    chk("long_err_cnt", 64'(err_cnt[0] - e0), 64'd1);
    chk("long_feat_clr", 64'(feat_o[0]), 64'd0);
    chk("long_s_ready", 64'(s_ready[0]), 64'd1);
    chk("long_no_result", 64'(mv_hi[0] - m0), 64'd0);
    rand_beats();
    send_frame(0, 7, 1'b1);
    wait_result(0);

    // Truncation: final beat 0xFF fills only the top three bits.
    rand_beats();
    beats[6] = 8'hFF;
    send_frame(0, 7, 1'b1);
    chk("trunc_top", 64'(feat_o[0][FEAT_W-1 -: 3]), 64'd7);
    chk("trunc_full", 64'(feat_o[0]), 64'(model_feat(N_CHUNK)));
    wait_result(0);

    // SETTLE=5 instance: nominal latency with the parity stub.
    rand_beats();
    send_frame(1, 7, 1'b1);
    wait_mvalid(1, n);
    chk("s5_latency", 64'(n), 64'(c_S1 + 1));
    wait_result(1);

    // Reset while the settle counter sits at 3.
    rand_beats();
    send_frame(1, 7, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n[1] = 1'b1;
    chk("mid_rst_m_valid", 64'(m_valid[1]), 64'd0);
    chk("mid_rst_m_class", 64'(m_class[1]), 64'd0);
    chk("mid_rst_feat",    64'(feat_o[1]),  64'd0);
    chk("mid_rst_err_len", 64'(err_len[1]), 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready[1]), 64'd1);
    m0 = mv_hi[1];
    repeat (12) @(posedge clk);
    #1;
    chk("mid_rst_no_stale", 64'(mv_hi[1] - m0), 64'd0);
    rand_beats();
    send_frame(1, 7, 1'b1);
    wait_result(1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained0", 64'(q0.size()), 64'd0);
    chk("sb_drained1", 64'(q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_tree_feature_loader
`default_nettype wire
